// File: rtl/alu_hs_pkg.sv
// Shared opcodes and FSM state type for the handshaked ALU.
// Opcodes above OP_LAST are illegal and return an error result.
package alu_hs_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_GT   = 4'd6;
  localparam logic [3:0] OP_LT   = 4'd7;
  localparam logic [3:0] OP_NOTA = 4'd8;
  localparam logic [3:0] OP_NOTB = 4'd9;
  localparam logic [3:0] OP_SHL  = 4'd10;
  localparam logic [3:0] OP_SHR  = 4'd11;
  localparam int         OP_LAST = 11;

  typedef enum logic {ST_IDLE, ST_MUL} state_e;

endpackage

// File: rtl/alu_hs_mul.sv
// Iterative shift-add multiplier: one bit of b per cycle, W cycles per product.
// done and prod are combinational so the caller captures the final iteration on the same edge.
module alu_hs_mul #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] prod
);

  localparam int CW = $clog2(W + 1);

  logic [CW-1:0]  cnt_q;
  logic [2*W-1:0] acc_q;
  logic [2*W-1:0] mcand_q;
  logic [W-1:0]   mplier_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start) begin
      cnt_q    <= CW'(W);
      acc_q    <= '0;
      mcand_q  <= {{W{1'b0}}, a};
      mplier_q <= b;
    end else if (cnt_q != '0) begin
      cnt_q    <= cnt_q - CW'(1);
      acc_q    <= prod;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

  // Partial sum including the current bit; on the last iteration this is the product.
  assign prod = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done = (cnt_q == CW'(1));

endmodule

// File: rtl/alu_hs.sv
// Handshaked ALU: valid/ready operand intake, registered 2W-bit result with z/c/err flags.
// Single-cycle ops complete in IDLE; MUL hands off to the iterative engine for W cycles.
module alu_hs
  import alu_hs_pkg::*;
#(
  parameter int W      = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [3:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] y,
  output logic           flag_z,
  output logic           flag_c,
  output logic           flag_err
);

  localparam int SW = $clog2(W);

  state_e         state_q, state_d;
  logic           out_valid_q, out_valid_d;
  logic [2*W-1:0] y_q, y_d;
  logic           z_q, z_d, c_q, c_d, err_q, err_d;

  logic           accept, deliver, mul_start, mul_done;
  logic [2*W-1:0] mul_prod, alu_y;
  logic           alu_c, alu_err;
  logic [W:0]     sum;
  logic [W-1:0]   diff, res_w;
  logic [SW-1:0]  shamt;
  logic           gt, lt;

  alu_hs_mul #(.W(W)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (a),
    .b     (b),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign deliver  = out_valid_q && out_ready;

  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = a - b;
  assign shamt = b[SW-1:0];
  assign gt    = SIGNED ? ($signed(a) > $signed(b)) : (a > b);
  assign lt    = SIGNED ? ($signed(a) < $signed(b)) : (a < b);

  always_comb begin
    res_w   = '0;
    alu_c   = 1'b0;
    alu_err = 1'b0;
    case (op)
      OP_ADD:  alu_c = sum[W];
      OP_SUB:  begin res_w = diff; alu_c = (a < b); end
      OP_MUL:  res_w = '0;
      OP_AND:  res_w = a & b;
      OP_OR:   res_w = a | b;
      OP_XOR:  res_w = a ^ b;
      OP_GT:   res_w = {{(W-1){1'b0}}, gt};
      OP_LT:   res_w = {{(W-1){1'b0}}, lt};
      OP_NOTA: res_w = ~a;
      OP_NOTB: res_w = ~b;
      OP_SHL:  res_w = a << shamt;
      OP_SHR:  res_w = a >> shamt;
      default: alu_err = (int'(op) > OP_LAST);
    endcase
    // ADD is the only single-cycle op whose result is wider than W.
    alu_y = (op == OP_ADD) ? {{(W-1){1'b0}}, sum} : {{W{1'b0}}, res_w};
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    y_d         = y_q;
    z_d         = z_q;
    c_d         = c_q;
    err_d       = err_q;
    mul_start   = 1'b0;
    if (deliver) out_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op == OP_MUL) begin
            state_d   = ST_MUL;
            mul_start = 1'b1;
          end else begin
            out_valid_d = 1'b1;
            y_d         = alu_y;
            z_d         = (alu_y == '0);
            c_d         = alu_c;
            err_d       = alu_err;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b1;
          y_d         = mul_prod;
          z_d         = (mul_prod == '0);
          c_d         = 1'b0;
          err_d       = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      z_q         <= z_d;
      c_q         <= c_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign flag_z    = z_q;
  assign flag_c    = c_q;
  assign flag_err  = err_q;

endmodule

// File: tb/tb_alu_hs.sv
// Directed bench for alu_hs: table of single-cycle vectors plus MUL, back-pressure and reset sequences.
// An unsigned and a signed instance share stimulus so compare results can be checked side by side.
module tb_alu_hs;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst, in_valid, out_ready;
  logic [3:0]     op;
  logic [W-1:0]   a, b;
  logic           in_ready, out_valid, flag_z, flag_c, flag_err;
  logic [2*W-1:0] y;
  logic           s_in_ready, s_out_valid, s_flag_z, s_flag_c, s_flag_err;
  logic [2*W-1:0] s_y;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_hs #(.W(W), .SIGNED(1'b0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .flag_z(flag_z), .flag_c(flag_c), .flag_err(flag_err)
  );

  alu_hs #(.W(W), .SIGNED(1'b1)) u_sgn (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .op(op), .a(a), .b(b),
    .out_valid(s_out_valid), .out_ready(out_ready), .y(s_y),
    .flag_z(s_flag_z), .flag_c(s_flag_c), .flag_err(s_flag_err)
  );

  typedef struct {
    logic [3:0]  op;
    logic [7:0]  a, b;
    logic [15:0] y, ys;
    logic        z, c, err;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] o, input logic [7:0] va, input logic [7:0] vb,
                              input logic [15:0] vy, input logic [15:0] vys,
                              input logic vz, input logic vc, input logic verr);
    vec_t v;
    v.op = o; v.a = va; v.b = vb; v.y = vy; v.ys = vys; v.z = vz; v.c = vc; v.err = verr;
    return v;
  endfunction

  task automatic run_mul(input logic [7:0] ma, input logic [7:0] mb, input logic [15:0] exp);
    int n;
    op = 4'd2; a = ma; b = mb; in_valid = 1'b1;
    #1 chk("mul_accept_rdy", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      chk("mul_busy_rdy", in_ready, 0);
      @(posedge clk); #1;
      n++;
    end
    chk("mul_latency", n, 8);
    chk("mul_y", y, exp);
    chk("mul_z", flag_z, exp == 16'h0);
    chk("mul_c", flag_c, 0);
    chk("mul_rdy_after", in_ready, 1);
  endtask

  initial begin
    vecs[0]  = mk(4'd0,  8'd200, 8'd100, 16'h012C, 16'h012C, 0, 1, 0);
    vecs[1]  = mk(4'd0,  8'hFF,  8'h01,  16'h0100, 16'h0100, 0, 1, 0);
    vecs[2]  = mk(4'd0,  8'h00,  8'h00,  16'h0000, 16'h0000, 1, 0, 0);
    vecs[3]  = mk(4'd1,  8'd5,   8'd7,   16'h00FE, 16'h00FE, 0, 1, 0);
    vecs[4]  = mk(4'd1,  8'd9,   8'd9,   16'h0000, 16'h0000, 1, 0, 0);
    vecs[5]  = mk(4'd3,  8'hF0,  8'h3C,  16'h0030, 16'h0030, 0, 0, 0);
    vecs[6]  = mk(4'd4,  8'hF0,  8'h0F,  16'h00FF, 16'h00FF, 0, 0, 0);
    vecs[7]  = mk(4'd5,  8'hAA,  8'hFF,  16'h0055, 16'h0055, 0, 0, 0);
    vecs[8]  = mk(4'd6,  8'h80,  8'h01,  16'h0001, 16'h0000, 0, 0, 0);
    vecs[9]  = mk(4'd7,  8'h80,  8'h01,  16'h0000, 16'h0001, 1, 0, 0);
    vecs[10] = mk(4'd6,  8'h7F,  8'hFF,  16'h0000, 16'h0001, 1, 0, 0);
    vecs[11] = mk(4'd8,  8'h0F,  8'h00,  16'h00F0, 16'h00F0, 0, 0, 0);
    vecs[12] = mk(4'd9,  8'h12,  8'h00,  16'h00FF, 16'h00FF, 0, 0, 0);
    vecs[13] = mk(4'd10, 8'h81,  8'h09,  16'h0002, 16'h0002, 0, 0, 0);
    vecs[14] = mk(4'd11, 8'h80,  8'h07,  16'h0001, 16'h0001, 0, 0, 0);
    vecs[15] = mk(4'd13, 8'h55,  8'h66,  16'h0000, 16'h0000, 1, 0, 1);
    vecs[16] = mk(4'd15, 8'hFF,  8'hFF,  16'h0000, 16'h0000, 1, 0, 1);
    vecs[17] = mk(4'd12, 8'h01,  8'h01,  16'h0000, 16'h0000, 1, 0, 1);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 4'd0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_flags", {flag_z, flag_c, flag_err}, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    // Back-to-back single-cycle ops: one result per cycle with out_valid held high.
    for (int i = 0; i < 18; i++) begin
      op = vecs[i].op; a = vecs[i].a; b = vecs[i].b; in_valid = 1'b1;
      #1 chk("vec_in_ready", in_ready, 1);
      @(posedge clk); #1;
      chk("vec_out_valid", out_valid, 1);
      chk("vec_y", y, vecs[i].y);
      chk("vec_z", flag_z, vecs[i].z);
      chk("vec_c", flag_c, vecs[i].c);
      chk("vec_err", flag_err, vecs[i].err);
      chk("vec_signed_y", s_y, vecs[i].ys);
    end
    in_valid = 1'b0;

    // Back-pressure: AND result held for 5 cycles while OR waits upstream.
    op = 4'd3; a = 8'hF0; b = 8'h3C; in_valid = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    op = 4'd4; a = 8'h0F; b = 8'h01;
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_y_hold", y, 16'h0030);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_rdy", in_ready, 1);
    @(posedge clk); #1;
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_y", y, 16'h000F);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain_valid", out_valid, 0);
    chk("drain_y_kept", y, 16'h000F);

    run_mul(8'd255, 8'd255, 16'hFE01);
    run_mul(8'd13, 8'd11, 16'h008F);
    run_mul(8'd0, 8'd77, 16'h0000);

    // MUL accepted on the same edge the previous result is delivered.
    op = 4'd0; a = 8'd1; b = 8'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("pre_mul_valid", out_valid, 1);
    run_mul(8'd200, 8'd3, 16'h0258);

    // Reset on the third cycle of a MUL: no result may appear afterwards.
    op = 4'd2; a = 8'd10; b = 8'd10; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_y", y, 0);
    chk("midrst_rdy", in_ready, 1);
    repeat (10) @(posedge clk);
    #1 chk("midrst_no_result", out_valid, 0);
    op = 4'd0; a = 8'd1; b = 8'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_y", y, 16'h0002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
